mux4_rr_sel: RTL and testbench
==============================

// Module: mux4_rr_sel
// PURPOSE
//  Round-robin, packet-aware grant controller sitting directly upstream of mux4: drives its en/sel.
//  Arbitrates four valid/ready sources onto one downstream valid/ready port.
//  Holds a grant until the granted source's last beat, or until HOLD_MAX beats have been
//  transferred. Data steering is done by mux4; this block moves no payload.
// PARAMETERS
//  HOLD_MAX  16  max beats per grant before forced release; 0 = unlimited (release only on last)
// PORTS
//  clk      in   1  single clock; all state updates on rising edge
//  rst      in   1  synchronous, active-high reset
//  req      in   4  per-source valid
//  last     in   4  per-source end-of-packet, qualified by req
//  ready    out  4  per-source ready; at most one bit set
//  o_valid  out  1  downstream valid (aligned with mux4 output o)
//  o_last   out  1  downstream end-of-packet
//  o_ready  in   1  downstream ready
//  en       out  1  to mux4.en; 1 while a grant is held
//  sel      out  2  to mux4.sel; index of granted source
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, en=0, sel=0, ptr=3, cnt=0. Combinational outputs
//    follow from this: ready=0, o_valid=0, o_last=0. Reset overrides any in-flight packet;
//    no transfer completes in the reset cycle.
//  Registered state:
//    state  IDLE/BUSY
//    ptr    2b, last granted index
//    cnt    beat count, $clog2(HOLD_MAX+1) bits, min 1
//    en, sel
//  Combinational outputs:
//    o_valid  = en & req[sel]
//    o_last   = o_valid & last[sel]
//    ready[i] = en & (sel==i) & o_ready
//    xfer     = o_valid & o_ready
//  IDLE:
//    req==0 -> stay; en=0; sel holds its previous value.
//    req!=0 -> pick the first set bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
//      Register sel=pick, en=1, cnt=0, state=BUSY.
//    Grant latency: 1 cycle from req to en.
//  BUSY:
//    xfer & (last[sel] | (HOLD_MAX!=0 & cnt==HOLD_MAX-1)) -> release:
//      ptr=sel, en=0, cnt=0, state=IDLE.
//    xfer, not releasing -> cnt=cnt+1; no wrap is possible below HOLD_MAX.
//    HOLD_MAX=0 -> cnt saturates at all-ones.
//    No xfer -> hold sel/en/cnt. A granted source that drops req mid-packet keeps the grant.
//  Release always inserts exactly one en=0 bubble cycle before the next grant, so mux4
//    outputs DISABLED for that cycle.
//  sel changes only on an IDLE->BUSY edge; sel is never changed while en=1.
//  Requests arriving at other inputs during BUSY are ignored until IDLE.
//  A forced HOLD_MAX release sets o_last=0 (packet not ended). The source re-competes
//    through round-robin and resumes its packet when next granted.
//  Transfer on the cycle rst is high: ignored; state still resets.
//  req/last/o_ready must be X-free when en=1; en/sel must never be X after reset.
// TESTING
//  1. Reset, then req=0001, last=0001, o_ready=1.
//     -> en=1, sel=0 one cycle later; ready=0001 for 1 cycle; then en=0.
//  2. req=1111, all last=1, o_ready=1, held.
//     -> grant order sel=0,1,2,3,0; each grant lasts 1 cycle; en=0 between grants.
//  3. Only src2 sends a 3-beat packet (last on beat 3); src1 raises req during beat 2.
//     -> sel=2 for 3 xfers with no interruption; bubble; then sel=1.
//  4. HOLD_MAX=4, src0 streams with last=0, src3 req=1.
//     -> en drops after the 4th xfer with o_last=0; next sel=3; then sel=0 resumes.
//  5. Granted src1, o_ready=0 for 5 cycles.
//     -> o_valid=1, ready=0000, cnt, sel and en stable; xfer on the first cycle o_ready=1.
//  6. rst=1 mid-packet (sel=2, cnt=3).
//     -> next cycle en=0, sel=0, ready=0000; after release with req=1111, first grant sel=0.

Source files
------------

// File: rtl/mux4_rr_sel_if.sv
// mux4_rr_sel_if: source-side valid/ready/last lanes, downstream port and mux4 en/sel.
//  req/last/o_ready driven by the environment; ready/o_valid/o_last/en/sel driven by the arbiter.
interface mux4_rr_sel_if;
  logic [3:0] req;
  logic [3:0] last;
  logic [3:0] ready;
  logic       o_valid;
  logic       o_last;
  logic       o_ready;
  logic       en;
  logic [1:0] sel;
  modport slave (input req, last, o_ready, output ready, o_valid, o_last, en, sel);
  modport master (output req, last, o_ready, input ready, o_valid, o_last, en, sel);
endinterface

// File: rtl/mux4_rr_sel.sv
// mux4_rr_sel: round-robin packet-aware grant controller driving mux4 en/sel.
//  clk, rst  : clock, synchronous active-high reset
//  bus.slave : req/last/ready per source, o_valid/o_last/o_ready downstream, en/sel to mux4
module mux4_rr_sel #(
  parameter int HOLD_MAX = 16
) (
  input logic          clk,
  input logic          rst,
  mux4_rr_sel_if.slave bus
);
  localparam int CW = HOLD_MAX == 0 ? 1 : $clog2(HOLD_MAX + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t          state_q;
  logic            en_q;
  logic [1:0]      sel_q;
  logic [1:0]      ptr_q;
  logic [1:0]      pick;
  logic [CW-1:0]   cnt_q;
  logic            o_valid;
  logic            xfer;
  logic            rel;
  assign o_valid     = en_q & bus.req[sel_q];
  assign xfer        = o_valid & bus.o_ready;
  assign rel         = bus.last[sel_q] | (HOLD_MAX != 0 && cnt_q == CW'(HOLD_MAX - 1));
  assign bus.o_valid = o_valid;
  assign bus.o_last  = o_valid & bus.last[sel_q];
  assign bus.ready   = {4{en_q & bus.o_ready}} & (4'b0001 << sel_q);
  assign bus.en      = en_q;
  assign bus.sel     = sel_q;
  // scan ptr+1..ptr+4 backwards so the nearest set bit after ptr wins
  always_comb begin
    pick = ptr_q;
    for (int k = 4; k >= 1; k--)
      if (bus.req[ptr_q + 2'(k)]) pick = ptr_q + 2'(k);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (|bus.req) begin
          sel_q   <= pick;
          en_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= BUSY;
        end
        BUSY: if (xfer) begin
          if (rel) begin
            ptr_q   <= sel_q;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux4_rr_sel.sv
// tb_mux4_rr_sel: directed table and sequence checks of the round-robin grant controller.
module tb_mux4_rr_sel;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  mux4_rr_sel_if bus ();
  mux4_rr_sel #(.HOLD_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic [3:0] ls;
    logic       ordy;
    logic       en;
    logic [1:0] sel;
    logic [3:0] rdy;
    logic       ov;
    logic       ol;
  } vec_t;
  task automatic chk(input string nm, input int idx, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %b expected %b", nm, idx, got, exp);
    end
  endtask
  // drive one cycle's inputs, check settled outputs, then advance one clock
  task automatic cyc(input vec_t v, input int idx);
    rst         = v.r;
    bus.req     = v.rq;
    bus.last    = v.ls;
    bus.o_ready = v.ordy;
    #1;
    chk("en", idx, {3'b0, bus.en}, {3'b0, v.en});
    chk("sel", idx, {2'b0, bus.sel}, {2'b0, v.sel});
    chk("ready", idx, bus.ready, v.rdy);
    chk("o_valid", idx, {3'b0, bus.o_valid}, {3'b0, v.ov});
    chk("o_last", idx, {3'b0, bus.o_last}, {3'b0, v.ol});
    @(posedge clk);
    #1;
  endtask
  vec_t tbl[16];
  initial begin
    bus.req = 4'b0; bus.last = 4'b0; bus.o_ready = 1'b1;
    // single beat from src0, then round-robin over four single-beat requesters
    tbl[0]  = '{1, 4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 0};
    tbl[1]  = '{0, 4'b0001, 4'b0001, 1, 0, 2'd0, 4'b0000, 0, 0};
    tbl[2]  = '{0, 4'b0001, 4'b0001, 1, 1, 2'd0, 4'b0001, 1, 1};
    tbl[3]  = '{0, 4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 0};
    tbl[4]  = '{1, 4'b1111, 4'b1111, 1, 0, 2'd0, 4'b0000, 0, 0};
    tbl[5]  = '{0, 4'b1111, 4'b1111, 1, 0, 2'd0, 4'b0000, 0, 0};
    tbl[6]  = '{0, 4'b1111, 4'b1111, 1, 1, 2'd0, 4'b0001, 1, 1};
    tbl[7]  = '{0, 4'b1111, 4'b1111, 1, 0, 2'd0, 4'b0000, 0, 0};
    tbl[8]  = '{0, 4'b1111, 4'b1111, 1, 1, 2'd1, 4'b0010, 1, 1};
    tbl[9]  = '{0, 4'b1111, 4'b1111, 1, 0, 2'd1, 4'b0000, 0, 0};
    tbl[10] = '{0, 4'b1111, 4'b1111, 1, 1, 2'd2, 4'b0100, 1, 1};
    tbl[11] = '{0, 4'b1111, 4'b1111, 1, 0, 2'd2, 4'b0000, 0, 0};
    tbl[12] = '{0, 4'b1111, 4'b1111, 1, 1, 2'd3, 4'b1000, 1, 1};
    tbl[13] = '{0, 4'b1111, 4'b1111, 1, 0, 2'd3, 4'b0000, 0, 0};
    tbl[14] = '{0, 4'b1111, 4'b1111, 1, 1, 2'd0, 4'b0001, 1, 1};
    tbl[15] = '{0, 4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) cyc(tbl[i], i);
    // src2 three-beat packet, src1 arrives mid-packet and waits for the bubble
    cyc('{0, 4'b0100, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 0}, 100);
    cyc('{0, 4'b0100, 4'b0000, 1, 1, 2'd2, 4'b0100, 1, 0}, 101);
    cyc('{0, 4'b0110, 4'b0000, 1, 1, 2'd2, 4'b0100, 1, 0}, 102);
    cyc('{0, 4'b0110, 4'b0100, 1, 1, 2'd2, 4'b0100, 1, 1}, 103);
    cyc('{0, 4'b0010, 4'b0010, 1, 0, 2'd2, 4'b0000, 0, 0}, 104);
    cyc('{0, 4'b0010, 4'b0010, 1, 1, 2'd1, 4'b0010, 1, 1}, 105);
    cyc('{0, 4'b0000, 4'b0000, 1, 0, 2'd1, 4'b0000, 0, 0}, 106);
    // src1 stalled five cycles; beat count must not advance, so release lands on the 4th real xfer
    cyc('{0, 4'b0010, 4'b0000, 0, 0, 2'd1, 4'b0000, 0, 0}, 200);
    for (int i = 0; i < 5; i++) cyc('{0, 4'b0010, 4'b0000, 0, 1, 2'd1, 4'b0000, 1, 0}, 201 + i);
    for (int i = 0; i < 4; i++) cyc('{0, 4'b0010, 4'b0000, 1, 1, 2'd1, 4'b0010, 1, 0}, 210 + i);
    cyc('{0, 4'b0000, 4'b0000, 1, 0, 2'd1, 4'b0000, 0, 0}, 214);
    // forced release after HOLD_MAX beats, src3 served, src0 resumes
    cyc('{1, 4'b0000, 4'b0000, 1, 0, 2'd1, 4'b0000, 0, 0}, 300);
    cyc('{0, 4'b1001, 4'b1000, 1, 0, 2'd0, 4'b0000, 0, 0}, 301);
    for (int i = 0; i < 4; i++) cyc('{0, 4'b1001, 4'b1000, 1, 1, 2'd0, 4'b0001, 1, 0}, 302 + i);
    cyc('{0, 4'b1001, 4'b1000, 1, 0, 2'd0, 4'b0000, 0, 0}, 306);
    cyc('{0, 4'b1001, 4'b1000, 1, 1, 2'd3, 4'b1000, 1, 1}, 307);
    cyc('{0, 4'b0001, 4'b1001, 1, 0, 2'd3, 4'b0000, 0, 0}, 308);
    cyc('{0, 4'b0001, 4'b1001, 1, 1, 2'd0, 4'b0001, 1, 1}, 309);
    // reset mid-packet with sel=2, cnt=3, then first grant from reset pointer
    cyc('{0, 4'b0100, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 0}, 400);
    for (int i = 0; i < 3; i++) cyc('{0, 4'b0100, 4'b0000, 1, 1, 2'd2, 4'b0100, 1, 0}, 401 + i);
    cyc('{1, 4'b1111, 4'b0000, 1, 1, 2'd2, 4'b0100, 1, 0}, 404);
    cyc('{0, 4'b1111, 4'b1111, 1, 0, 2'd0, 4'b0000, 0, 0}, 405);
    cyc('{0, 4'b1111, 4'b1111, 1, 1, 2'd0, 4'b0001, 1, 1}, 406);
    cyc('{0, 4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 0}, 407);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
